pip_reg_gen: RTL

Parametrised, multi-stage pipeline register for the RV32I core. It replaces the fixed-field, always-loading stage registers with a generic stage that carries:
- a payload (PC, ALU result, immediate, store data, rd);
- a control field (write enables, mux selects);
- a valid bit per stage.

It adds global stall (hold), per-stage flush (bubble insertion), async reset and a saturating bubble counter for CPI profiling. One instance per pipeline boundary, or one multi-stage instance for a chain such as EX/MEM/WB.

---
 rtl/core_pkg.sv | 20 ++
 rtl/pip_stage.sv | 35 +++
 rtl/pip_reg_gen.sv | 87 ++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: architectural widths and the decoded control
// field that travels with each instruction through the pipeline registers.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int MAX_STAGES = 8;

  typedef struct packed {
    logic       lui;
    logic       mem_mux;
    logic [2:0] dmem_we;
    logic       reg_we;
    logic [1:0] wb_mux;
  } ctrl_t;

  // Width of the control field, derived from the struct so they cannot drift apart.
  localparam int CTRL_FIELD_W = $bits(ctrl_t);

endpackage

// File: rtl/pip_stage.sv
// One pipeline boundary register: flush beats stall beats load.
// A loaded bubble always carries an all-zero control field.
module pip_stage #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              load_valid,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (flush) begin
      // Payload is left alone; only the entry's validity and side effects are killed.
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (!stall) begin
      valid <= load_valid;
      ctrl  <= load_ctrl & {CTRL_W{load_valid}};
      data  <= load_data;
    end
  end

endmodule

// File: rtl/pip_reg_gen.sv
// Generic multi-stage pipeline register with global stall, per-stage flush
// and a saturating count of bubbles reaching the last stage.
module pip_reg_gen
  import core_pkg::*;
#(
  parameter int DATA_W     = 96,
  parameter int CTRL_W     = core_pkg::CTRL_FIELD_W,
  parameter int NUM_STAGES = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [CTRL_W-1:0]     ctrl_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  stall_i,
  input  logic [NUM_STAGES-1:0] flush_i,
  input  logic                  cnt_clr_i,
  output logic                  valid_o,
  output logic [CTRL_W-1:0]     ctrl_o,
  output logic [DATA_W-1:0]     data_o,
  output logic [NUM_STAGES-1:0] stage_valid_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
);

  if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
    $error("pip_reg_gen: NUM_STAGES must be in 1..%0d", MAX_STAGES);
  end

  logic [NUM_STAGES-1:0] stage_valid;
  logic [NUM_STAGES-1:0] load_valid;
  logic [CTRL_W-1:0]     stage_ctrl [NUM_STAGES];
  logic [CTRL_W-1:0]     load_ctrl  [NUM_STAGES];
  logic [DATA_W-1:0]     stage_data [NUM_STAGES];
  logic [DATA_W-1:0]     load_data  [NUM_STAGES];

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign load_valid[gi] = valid_i;
      assign load_ctrl[gi]  = ctrl_i;
      assign load_data[gi]  = data_i;
    end else begin : g_chain
      assign load_valid[gi] = stage_valid[gi-1];
      assign load_ctrl[gi]  = stage_ctrl[gi-1];
      assign load_data[gi]  = stage_data[gi-1];
    end

    pip_stage #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush_i[gi]),
      .stall      (stall_i),
      .load_valid (load_valid[gi]),
      .load_ctrl  (load_ctrl[gi]),
      .load_data  (load_data[gi]),
      .valid      (stage_valid[gi]),
      .ctrl       (stage_ctrl[gi]),
      .data       (stage_data[gi])
    );
  end

  // A bubble is counted on any advancing edge that leaves the last stage invalid.
  logic             out_bubble;
  logic [CNT_W-1:0] bubble_cnt;

  assign out_bubble = !stall_i && (flush_i[NUM_STAGES-1] || !load_valid[NUM_STAGES-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (cnt_clr_i) begin
      bubble_cnt <= '0;
    end else if (out_bubble && bubble_cnt != {CNT_W{1'b1}}) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  assign valid_o       = stage_valid[NUM_STAGES-1];
  assign ctrl_o        = stage_ctrl[NUM_STAGES-1];
  assign data_o        = stage_data[NUM_STAGES-1];
  assign stage_valid_o = stage_valid;
  assign bubble_cnt_o  = bubble_cnt;

endmodule
